// File: rtl/serial_restore_adder_if.sv
// Handshake/data bundle for serial_restore_adder.
// The mode signal exists only when SERIAL_SUB_MODE_EN is defined.
interface serial_restore_adder_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_SUB_MODE_EN
    logic             mode;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] a;
    logic             ovf;

    modport master (
`ifdef SERIAL_SUB_MODE_EN
        output mode,
`endif
        output start, diff, b,
        input  busy, done, a, ovf
    );

    modport slave (
`ifdef SERIAL_SUB_MODE_EN
        input  mode,
`endif
        input  start, diff, b,
        output busy, done, a, ovf
    );
endinterface

// File: rtl/serial_restore_adder.sv
// Bit-serial adder recovering A = diff + b, LSB first, one bit per clock.
// Optional SERIAL_SUB_MODE_EN adds a mode input selecting diff - b instead.
module serial_restore_adder #(
    parameter int WIDTH = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    serial_restore_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    logic [WIDTH:0]   d_r;
    logic [WIDTH:0]   e_r;
    logic [WIDTH:0]   s_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] a_r;
    logic             ovf_r;

    logic             sum_s;
    logic             cout_s;
    logic [WIDTH:0]   s_next_s;
    logic [WIDTH:0]   e_load_s;
    logic             carry_load_s;

    // Returns {carry_out, sum} of a one-bit full adder.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic cin);
        full_add = {(x & y) | (x & cin) | (y & cin), x ^ y ^ cin};
    endfunction

    // Current bit sum and the result register as it will look after this bit.
    always_comb begin
        {cout_s, sum_s} = full_add(d_r[0], e_r[0], carry_r);
        s_next_s        = {sum_s, s_r[WIDTH:1]};
    end

    // Subtraction is addition of the one's complement with a carry-in of one.
    always_comb begin
`ifdef SERIAL_SUB_MODE_EN
        if (bus.mode) begin
            e_load_s     = ~{1'b0, bus.b};
            carry_load_s = 1'b1;
        end else begin
            e_load_s     = {1'b0, bus.b};
            carry_load_s = 1'b0;
        end
`else
        e_load_s     = {1'b0, bus.b};
        carry_load_s = 1'b0;
`endif
    end

    // Control FSM and serial datapath with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            d_r     <= {(WIDTH+1){1'b0}};
            e_r     <= {(WIDTH+1){1'b0}};
            s_r     <= {(WIDTH+1){1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            a_r     <= {WIDTH{1'b0}};
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        d_r     <= bus.diff;
                        e_r     <= e_load_s;
                        s_r     <= {(WIDTH+1){1'b0}};
                        carry_r <= carry_load_s;
                        cnt_r   <= {CW{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= SHIFT;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                SHIFT: begin
                    s_r     <= s_next_s;
                    d_r     <= {1'b0, d_r[WIDTH:1]};
                    e_r     <= {1'b0, e_r[WIDTH:1]};
                    carry_r <= cout_s;
                    cnt_r   <= cnt_r + CW'(1);
                    if (cnt_r == LAST_BIT) begin
                        a_r     <= s_next_s[WIDTH-1:0];
                        ovf_r   <= s_next_s[WIDTH];
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.a    = a_r;
    assign bus.ovf  = ovf_r;
endmodule
